// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared saturating 16-bit add/sub unit.
// Operands are registered on accept; the result is held until the consumer takes it.

module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g_s;
    logic [15:0] p_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    function automatic logic [4:0] blk_carry(input logic [3:0] g4, input logic [3:0] p4,
                                             input logic ci);
        logic [4:0] c;
        c[0] = ci;
        c[1] = g4[0] | (p4[0] & ci);
        c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
        c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
             | (p4[2] & p4[1] & p4[0] & ci);
        c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
             | (p4[3] & p4[2] & p4[1] & g4[0]) | (p4[3] & p4[2] & p4[1] & p4[0] & ci);
        return c;
    endfunction

    // Four 4-bit lookahead blocks chained on their group carries.
    always_comb begin
        logic       carry_v;
        logic [4:0] blk_v;
        carry_v = cin;
        sum     = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            blk_v          = blk_carry(g_s[4*k +: 4], p_s[4*k +: 4], carry_v);
            sum[4*k +: 4]  = p_s[4*k +: 4] ^ blk_v[3:0];
            carry_v        = blk_v[4];
        end
        cout = carry_v;
    end

endmodule

module addsub_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_ovfl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        op_sub_q, op_sub_d;
    logic        op_id_q, op_id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_ovfl_q, rsp_ovfl_d;

    logic        grant0_s;
    logic        grant1_s;
    logic [15:0] add_b_s;
    logic [15:0] sum_s;
    logic        unused_cout_s;
    logic        ovfl_s;
    logic [15:0] sat_s;

    // Grant only in IDLE and never while reset is asserted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_q == IDLE) && rst_n) begin
            case ({req1_valid, req0_valid})
                2'b01:   grant0_s = 1'b1;
                2'b10:   grant1_s = 1'b1;
                2'b11: begin
                    if ((FIXED_PRIO != 0) || !rr_ptr_q) begin
                        grant0_s = 1'b1;
                    end else begin
                        grant1_s = 1'b1;
                    end
                end
                default: grant0_s = 1'b0;
            endcase
        end else begin
            grant0_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    assign add_b_s = op_sub_q ? ~op_b_q : op_b_q;

    cla_16bit u_cla (
        .a    (op_a_q),
        .b    (add_b_s),
        .cin  (op_sub_q),
        .sum  (sum_s),
        .cout (unused_cout_s)
    );

    // Overflow: both adder inputs share a sign that the sum does not.
    assign ovfl_s = (op_a_q[15] == add_b_s[15]) && (sum_s[15] != op_a_q[15]);
    assign sat_s  = ovfl_s ? (op_a_q[15] ? 16'h8000 : 16'h7FFF) : sum_s;

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovfl_d  = rsp_ovfl_q;
        case (state_q)
            IDLE: begin
                if (grant0_s) begin
                    op_a_d   = req0_a;
                    op_b_d   = req0_b;
                    op_sub_d = req0_sub;
                    op_id_d  = 1'b0;
                    state_d  = EXEC;
                end else if (grant1_s) begin
                    op_a_d   = req1_a;
                    op_b_d   = req1_b;
                    op_sub_d = req1_sub;
                    op_id_d  = 1'b1;
                    state_d  = EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                rsp_data_d  = sat_s;
                rsp_ovfl_d  = ovfl_s;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                rr_ptr_d    = ~op_id_q;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_sub_q    <= 1'b0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_ovfl_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovfl_q  <= rsp_ovfl_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ovfl  = rsp_ovfl_q;

endmodule
